// File: rtl/uart_pkg.sv
// uart_pkg: parity encodings and transmitter state type shared by the UART transmitter
package uart_pkg;
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; full/empty guard push/pop
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  output logic [W-1:0]  head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_ptr + AW'(pop_ok);
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with run-time divisor, parity and stop-bit framing
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [DIV_W-1:0]              divisor,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int BW = $clog2(DATA_W + 1);
  tx_state_t state, state_next;
  logic [DIV_W-1:0] div_l, cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_W-1:0] sh, sh_next, head;
  logic [1:0] par_l;
  logic two_l, par_bit, txd_next, pop, empty, full, bit_end, last_bit;

  sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk, .rst_n,
    .push(wr_valid && wr_ready),
    .pop,
    .push_data(wr_data),
    .full, .empty,
    .level(fifo_level),
    .head
  );

  assign wr_ready = !full;
  assign busy = state != IDLE;
  assign bit_end = state != IDLE && cnt == div_l - DIV_W'(1);
  assign last_bit = state == DATA ? bit_cnt == BW'(DATA_W - 1) : bit_cnt == BW'(two_l);
  // Popping at the end of the last stop bit chains frames with no idle gap
  assign pop = !empty && (state == IDLE || (state == STOP && bit_end && last_bit));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      txd <= 1'b1;
      sh <= '0;
      cnt <= '0;
      bit_cnt <= '0;
      div_l <= DIV_W'(1);
      par_l <= PAR_NONE;
      two_l <= 1'b0;
      par_bit <= 1'b0;
    end else begin
      state <= state_next;
      txd <= txd_next;
      sh <= sh_next;
      cnt <= (pop || bit_end || state == IDLE) ? '0 : cnt + DIV_W'(1);
      bit_cnt <= state_next != state ? '0 : bit_end ? bit_cnt + BW'(1) : bit_cnt;
      if (pop) begin
        div_l <= divisor == '0 ? DIV_W'(1) : divisor;
        par_l <= parity_mode;
        two_l <= two_stop;
        par_bit <= ^head ^ (parity_mode == PAR_ODD);
      end
    end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = empty ? IDLE : START;
      START:   state_next = bit_end ? DATA : START;
      DATA:    state_next = !(bit_end && last_bit) ? DATA :
                            (par_l == PAR_EVEN || par_l == PAR_ODD) ? PARITY : STOP;
      PARITY:  state_next = bit_end ? STOP : PARITY;
      STOP:    state_next = !(bit_end && last_bit) ? STOP : empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // txd is computed from the state being entered so the registered line lines up with it
  always_comb begin
    sh_next = pop ? head : (state == DATA && bit_end) ? sh >> 1 : sh;
    txd_next = state_next == START  ? 1'b0 :
               state_next == DATA   ? sh_next[0] :
               state_next == PARITY ? par_bit : 1'b1;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, buffered UART transmitter that replaces the bare `q`-to-`uart_txd` tie-off in the top-level wrapper. It accepts words over a valid/ready write port into an internal FIFO. Each word is serialised as start bit, data LSB first, optional parity, then one or two stop bits. Bit period and framing are set at run time. The serial output drives `uo_out[1]`.

## Interface
Parameters:
- `DATA_W`, 8: data bits per frame; legal range 5..9.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DIV_W`, 16: width of the baud divisor input.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `wr_data` in DATA_W: word to transmit.
- `wr_valid` in 1: `wr_data` is valid.
- `wr_ready` out 1: FIFO can accept a word.
- `divisor` in DIV_W: clocks per bit; 0 is treated as 1.
- `parity_mode` in 2: 0 none, 1 even, 2 odd, 3 none.
- `two_stop` in 1: 1 selects two stop bits.
- `txd` out 1: serial line, idle high.
- `busy` out 1: a frame is in progress.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: number of occupied entries.

## Operation
- Write handshake: a word is written when `wr_valid && wr_ready` at a rising edge.
- `wr_ready = (fifo_level != FIFO_DEPTH)`. There is no same-cycle bypass when the FIFO is full, even if a pop happens in that cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. This transition pops the head word into the shift register and latches `divisor`, `parity_mode` and `two_stop` for the whole frame.
  - START → DATA after one bit period.
  - DATA shifts out DATA_W bits, LSB first, one per bit period.
  - DATA → PARITY if the latched mode is 1 or 2; otherwise DATA → STOP.
  - PARITY sends one bit. Even: XOR of the data bits. Odd: inverse of that XOR.
  - STOP drives 1 for one bit period, or two if `two_stop` was latched.
  - At the end of STOP: go to START with an immediate pop if the FIFO is non-empty (no idle gap), otherwise go to IDLE.
- `txd` values by state: 1 in IDLE/STOP, 0 in START, shift LSB in DATA, parity bit in PARITY. `txd` is registered and glitch-free.
- `busy = (state != IDLE)`.
- Bit timer: counts 0..max(divisor,1)−1 from the latched divisor. Changes on the `divisor` input take effect only at the next frame.
- `fifo_level` is updated every cycle. A simultaneous push and pop leaves it unchanged.
- Reset values: `txd`=1, `busy`=0, `wr_ready`=1, `fifo_level`=0, state IDLE, FIFO pointers 0.
- Reset asserted mid-frame aborts the frame and flushes the FIFO. `txd` returns to 1 asynchronously.

## Timing
- Latency: a word written at edge N into an empty FIFO while IDLE is popped at edge N+1. `txd` goes low and `busy` goes high from edge N+1.
- Frame length in clocks: max(divisor,1) × (1 + DATA_W + P + S), where P ∈ {0,1} and S ∈ {1,2}.
- Back-to-back frames: the next start bit begins on the edge immediately after the last stop-bit period ends.
- A pop and a write in the same cycle are both honoured. Pointers wrap modulo FIFO_DEPTH.
- `wr_ready` falls on the edge that makes the FIFO full. It rises on the edge of the pop that frees an entry.

## Structure
- Package `uart_pkg`:
  - parity encodings `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`;
  - FSM state typedef `tx_state_t`.
- Sub-module `sync_fifo`, parametrised by width and depth:
  - ports: push, pop, full, empty, level, head data;
  - same `clk`/`rst_n` reset scheme.
- The FSM, bit timer and shift register live in `uart_tx_fifo`.

## Test plan
- Basic frame: 0xA5, divisor=4, parity none, one stop bit. Required `txd`: 0,1,0,1,0,0,1,0,1,1, each bit held 4 clocks. `busy` is high for exactly 40 clocks.
- Parity: 0x07 with even parity gives parity bit 1. 0x07 with odd parity gives 0. 0x00 with even parity gives 0. With `two_stop`=1 the frame is 12 bit periods.
- FIFO fill: write 5 words back-to-back with FIFO_DEPTH=4 while the transmitter is IDLE.
  - The first word pops at the edge after its write, so `fifo_level` peaks at 4 after the fifth write is accepted.
  - Write a sixth word while the FIFO is full: `wr_ready`=0 and the sixth write stalls until the next pop, 10×divisor clocks later.
  - All 6 frames come out in order with no idle gap between them.
- Config latching: change `divisor` from 4 to 8 in the middle of a frame. The current frame keeps 4-clock bits; the next frame uses 8-clock bits.
- Divisor 0: every bit lasts 1 clock and a frame is 10 clocks.
- Reset mid-frame: assert `rst_n`=0 during the DATA state with 3 words queued. `txd`=1 and `busy`=0 immediately. After reset `fifo_level`=0 and no frame starts.
